// File: rtl/glb_arb_pkg.sv
// Shared types and the round-robin pick helper for the GLB read arbiter.
// Tag width is sized for the largest supported requester count (8).
package glb_arb_pkg;

  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned TAG_W   = $clog2(MAX_REQ);
  localparam int unsigned BURST_W = 8;

  typedef enum logic {
    ST_IDLE,
    ST_LOCK
  } arb_state_e;

  typedef struct packed {
    logic               found;
    logic [TAG_W-1:0]   idx;
    logic [MAX_REQ-1:0] onehot;
  } rr_pick_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } ret_tag_t;

  // First requester with req set, searching from ptr upward modulo n.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                       input logic [TAG_W-1:0]   ptr,
                                       input int unsigned        n);
    rr_pick_t         res;
    logic [TAG_W-1:0] pos;
    res = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      pos = TAG_W'((32'(ptr) + i) % n);
      if (i < n && !res.found && req[pos]) begin
        res.found       = 1'b1;
        res.idx         = pos;
        res.onehot[pos] = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/glb_read_arbiter_if.sv
// Router-side and GLB-side bus of the GLB read arbiter.
// slave = arbiter view, master = requesters plus GLB view.
interface glb_read_arbiter_if #(
  parameter int unsigned N_REQ             = 4,
  parameter int unsigned ADDR_BITWIDTH_GLB = 10,
  parameter int unsigned DATA_BITWIDTH     = 16
);
  logic [N_REQ-1:0]                   req_i;
  logic [N_REQ*ADDR_BITWIDTH_GLB-1:0] addr_i;
  logic [N_REQ-1:0]                   gnt_o;
  logic [ADDR_BITWIDTH_GLB-1:0]       glb_addr_o;
  logic                               glb_req_o;
  logic [DATA_BITWIDTH-1:0]           glb_data_i;
  logic [DATA_BITWIDTH-1:0]           rdata_o;
  logic [N_REQ-1:0]                   rvalid_o;

  modport slave (
    input  req_i, addr_i, glb_data_i,
    output gnt_o, glb_addr_o, glb_req_o, rdata_o, rvalid_o
  );

  modport master (
    output req_i, addr_i, glb_data_i,
    input  gnt_o, glb_addr_o, glb_req_o, rdata_o, rvalid_o
  );
endinterface

// File: rtl/glb_ret_pipe.sv
// Fixed-latency {valid, tag} shift register steering GLB read data back
// to the issuing requester, with the data retimed to line up with rvalid.
module glb_ret_pipe
  import glb_arb_pkg::*;
#(
  parameter int unsigned N_REQ         = 4,
  parameter int unsigned DATA_BITWIDTH = 16,
  parameter int unsigned READ_LATENCY  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_valid,
  input  logic [TAG_W-1:0]         i_tag,
  input  logic [DATA_BITWIDTH-1:0] i_data,
  output logic [N_REQ-1:0]         o_rvalid,
  output logic [DATA_BITWIDTH-1:0] o_rdata,
  output logic                     o_busy
);

  ret_tag_t         r_pipe [READ_LATENCY];
  ret_tag_t         w_last;
  logic [N_REQ-1:0] w_hit;

  assign w_last = r_pipe[READ_LATENCY-1];

  always_comb begin
    w_hit = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_hit[k] = w_last.valid && (w_last.tag == TAG_W'(k));
    end
    o_busy = 1'b0;
    for (int unsigned s = 0; s < READ_LATENCY; s++) begin
      o_busy = o_busy | r_pipe[s].valid;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned s = 0; s < READ_LATENCY; s++) begin
        r_pipe[s] <= '0;
      end
      o_rvalid <= '0;
      o_rdata  <= '0;
    end else begin
      r_pipe[0] <= '{valid: i_valid, tag: i_tag};
      for (int unsigned s = 1; s < READ_LATENCY; s++) begin
        r_pipe[s] <= r_pipe[s-1];
      end
      o_rvalid <= w_hit;
      o_rdata  <= i_data;
    end
  end

endmodule

// File: rtl/glb_read_arbiter.sv
// Round-robin GLB read-port arbiter with bounded burst lock and tagged return.
// Define GLB_ARB_FIXED_PRIO_EN to pin the search pointer at 0 (fixed priority).
module glb_read_arbiter
  import glb_arb_pkg::*;
#(
  parameter int unsigned DATA_BITWIDTH     = 16,
  parameter int unsigned ADDR_BITWIDTH_GLB = 10,
  parameter int unsigned N_REQ             = 4,
  parameter int unsigned READ_LATENCY      = 1,
  parameter int unsigned MAX_BURST         = 8
) (
  input  logic               clk,
  input  logic               reset,
  glb_read_arbiter_if.slave  bus,
  output logic               busy_o
);

  arb_state_e                   r_state;
  logic [TAG_W-1:0]             r_owner;
  logic [TAG_W-1:0]             r_rr_ptr;
  logic [BURST_W-1:0]           r_burst_cnt;
  logic [ADDR_BITWIDTH_GLB-1:0] r_last_addr;

  logic [MAX_REQ-1:0]           w_req_ext;
  logic [TAG_W-1:0]             w_next_ptr;
  logic [TAG_W-1:0]             w_pick_ptr;
  rr_pick_t                     w_pick;
  logic                         w_keep;
  logic                         w_grant;
  logic [TAG_W-1:0]             w_gnt_idx;
  logic [MAX_REQ-1:0]           w_gnt_ext;
  logic [MAX_REQ-1:0]           w_unused_gnt_ext;
  logic [N_REQ-1:0]             w_gnt;
  logic [ADDR_BITWIDTH_GLB-1:0] w_sel_addr;
  logic                         w_pipe_busy;

`ifdef GLB_ARB_FIXED_PRIO_EN
  assign w_next_ptr = '0;
`else
  assign w_next_ptr = (r_owner == TAG_W'(N_REQ - 1)) ? '0 : r_owner + 1'b1;
`endif

  // In LOCK the handover pick already starts from the advanced pointer,
  // so the new owner is granted in the same cycle (no bubble).
  always_comb begin
    w_req_ext             = '0;
    w_req_ext[N_REQ-1:0]  = bus.req_i;
    w_keep     = (r_state == ST_LOCK) && w_req_ext[r_owner]
                 && (r_burst_cnt < BURST_W'(MAX_BURST));
    w_pick_ptr = (r_state == ST_LOCK) ? w_next_ptr : r_rr_ptr;
    w_pick     = rr_pick(w_req_ext, w_pick_ptr, N_REQ);
    w_grant    = reset && (w_keep || w_pick.found);
    w_gnt_idx  = w_keep ? r_owner : w_pick.idx;
    w_gnt_ext  = '0;
    if (w_grant) begin
      if (w_keep) w_gnt_ext[r_owner] = 1'b1;
      else        w_gnt_ext = w_pick.onehot;
    end
  end

  assign w_gnt            = w_gnt_ext[N_REQ-1:0];
  assign w_unused_gnt_ext = w_gnt_ext;

  always_comb begin
    w_sel_addr = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (w_gnt[k]) w_sel_addr = bus.addr_i[k*ADDR_BITWIDTH_GLB +: ADDR_BITWIDTH_GLB];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
      r_last_addr <= '0;
    end else begin
      if (w_grant) r_last_addr <= w_sel_addr;
      if (w_keep) begin
        r_burst_cnt <= r_burst_cnt + 1'b1;
      end else begin
        if (r_state == ST_LOCK) r_rr_ptr <= w_next_ptr;
        if (w_pick.found) begin
          r_state     <= ST_LOCK;
          r_owner     <= w_pick.idx;
          r_burst_cnt <= BURST_W'(1);
        end else begin
          r_state     <= ST_IDLE;
          r_burst_cnt <= '0;
        end
      end
    end
  end

  assign bus.gnt_o      = w_gnt;
  assign bus.glb_req_o  = w_grant;
  assign bus.glb_addr_o = w_grant ? w_sel_addr : r_last_addr;
  assign busy_o         = (r_state == ST_LOCK) | w_pipe_busy;

  glb_ret_pipe #(
    .N_REQ        (N_REQ),
    .DATA_BITWIDTH(DATA_BITWIDTH),
    .READ_LATENCY (READ_LATENCY)
  ) u_ret_pipe (
    .clk     (clk),
    .reset   (reset),
    .i_valid (w_grant),
    .i_tag   (w_gnt_idx),
    .i_data  (bus.glb_data_i),
    .o_rvalid(bus.rvalid_o),
    .o_rdata (bus.rdata_o),
    .o_busy  (w_pipe_busy)
  );

endmodule

// File: tb/tb_glb_read_arbiter.sv
// Scoreboard bench for glb_read_arbiter: directed request patterns, expected
// grants and tagged returns queued at stimulus time, checked by a monitor.
module tb_glb_read_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 16;
  localparam int unsigned RL = 3;
`ifdef GLB_ARB_FIXED_PRIO_EN
  localparam int unsigned MB = 2;
`else
  localparam int unsigned MB = 4;
`endif

  logic clk = 1'b0;
  logic reset;
  logic busy;

  glb_read_arbiter_if #(.N_REQ(NR), .ADDR_BITWIDTH_GLB(AW), .DATA_BITWIDTH(DW)) bus ();

  glb_read_arbiter #(
    .DATA_BITWIDTH    (DW),
    .ADDR_BITWIDTH_GLB(AW),
    .N_REQ            (NR),
    .READ_LATENCY     (RL),
    .MAX_BURST        (MB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] glb_f(input logic [AW-1:0] a);
    return DW'(a) * 16'd7 + 16'h1234;
  endfunction

  // GLB memory model: data for the address requested in cycle c appears in cycle c+RL
  logic [AW-1:0] cap;
  logic [AW-1:0] dl [RL];
  always @(negedge clk) cap <= bus.glb_addr_o;
  always @(posedge clk) begin
    dl[0] <= cap;
    for (int unsigned i = 1; i < RL; i++) dl[i] <= dl[i-1];
  end
  assign bus.glb_data_i = glb_f(dl[RL-1]);

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct {
    logic [NR-1:0] gnt;
    logic [AW-1:0] addr;
  } gexp_t;

  typedef struct {
    int            due;
    logic [NR-1:0] vld;
    logic [DW-1:0] data;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  gexp_t g_m;
  rexp_t r_m;

  always @(negedge clk) begin
    if (gq.size() > 0) begin
      g_m = gq.pop_front();
      chk("gnt", 32'(bus.gnt_o), 32'(g_m.gnt));
      chk("glb_req", 32'(bus.glb_req_o), 32'(|g_m.gnt));
      chk("glb_addr", 32'(bus.glb_addr_o), 32'(g_m.addr));
    end
    if (bus.rvalid_o != '0) begin
      if (rq.size() == 0) begin
        chk("rvalid_spurious", 32'(bus.rvalid_o), 32'd0);
      end else begin
        r_m = rq.pop_front();
        chk("rvalid_cycle", 32'(cyc), 32'(r_m.due));
        chk("rvalid", 32'(bus.rvalid_o), 32'(r_m.vld));
        chk("rdata", 32'(bus.rdata_o), 32'(r_m.data));
      end
    end else if (rq.size() > 0 && rq[0].due <= cyc) begin
      r_m = rq.pop_front();
      chk("rvalid_missing", 32'(bus.rvalid_o), 32'(r_m.vld));
    end
  end

  logic [AW-1:0] a [NR];
  logic [AW-1:0] last_addr;

  task automatic step(input logic [NR-1:0] req, input logic [NR-1:0] eg);
    logic [AW-1:0] ea;
    @(posedge clk);
    #1;
    bus.req_i = req;
    for (int unsigned k = 0; k < NR; k++) bus.addr_i[k*AW +: AW] = a[k];
    ea = last_addr;
    for (int unsigned k = 0; k < NR; k++) if (eg[k]) ea = a[k];
    gq.push_back('{gnt: eg, addr: ea});
    if (eg != '0) begin
      rq.push_back('{due: cyc + int'(RL) + 1, vld: eg, data: glb_f(ea)});
      last_addr = ea;
    end
    for (int unsigned k = 0; k < NR; k++) if (eg[k]) a[k] = a[k] + 1'b1;
  endtask

  task automatic drain(input int n);
    repeat (n) step(4'b0000, 4'b0000);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, 32'(bus.gnt_o), 32'd0);
    chk({tag, "_glb_req"}, 32'(bus.glb_req_o), 32'd0);
    chk({tag, "_rvalid"}, 32'(bus.rvalid_o), 32'd0);
    chk({tag, "_rdata"}, 32'(bus.rdata_o), 32'd0);
    chk({tag, "_glb_addr"}, 32'(bus.glb_addr_o), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    bus.req_i  = '0;
    bus.addr_i = '0;
    a[0] = 10'h000; a[1] = 10'h010; a[2] = 10'h200; a[3] = 10'h300;
    last_addr = '0;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.req_i = 4'b0001;
    #1;
    chk_all_zero("reset");
    bus.req_i = '0;
    @(posedge clk);
    #1 reset = 1'b1;

    // single requester, addresses 0x010..0x012
    repeat (3) step(4'b0010, 4'b0010);
    step(4'b0000, 4'b0000);
    drain(5);

`ifndef GLB_ARB_FIXED_PRIO_EN
    // burst limit of 4 alternating between req0 and req1
    repeat (4) step(4'b0011, 4'b0001);
    repeat (4) step(4'b0011, 4'b0010);
    repeat (4) step(4'b0011, 4'b0001);
    step(4'b0011, 4'b0010);
    chk("busy_lock", 32'(busy), 32'd1);
    step(4'b0011, 4'b0010);
    step(4'b0000, 4'b0000);
    drain(5);

    // early release with req2 pending, then interleaved req0/req3
    step(4'b0001, 4'b0001);
    step(4'b0101, 4'b0001);
    step(4'b0100, 4'b0100);
    step(4'b0100, 4'b0100);
    step(4'b1011, 4'b1000);
    step(4'b0001, 4'b0001);
    step(4'b1000, 4'b1000);
    step(4'b0001, 4'b0001);
    step(4'b1000, 4'b1000);
    step(4'b0000, 4'b0000);
    drain(6);
`else
    // fixed priority: req0 keeps winning every re-arbitration
    repeat (8) step(4'b1111, 4'b0001);
    step(4'b0000, 4'b0000);
    drain(6);
`endif

    // reset with reads in flight
    repeat (3) step(4'b0100, 4'b0100);
    step(4'b0000, 4'b0000);
    @(posedge clk);
    #1;
    chk("rvalid_before_reset", 32'(bus.rvalid_o), 32'(4'b0100));
    reset     = 1'b0;
    bus.req_i = 4'b0001;
    rq.delete();
    gq.delete();
    last_addr = '0;
    #1;
    chk_all_zero("midreset");
    @(posedge clk);
    #1;
    bus.req_i = '0;
    reset     = 1'b1;
    drain(6);
    step(4'b0010, 4'b0010);
    step(4'b0000, 4'b0000);
    drain(6);

    @(posedge clk);
    #1;
    chk("pending_returns", 32'(rq.size()), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/glb_read_arbiter.md
Name: glb_read_arbiter

Overview:
- Shares one global-buffer (GLB) read port between N_REQ router requesters, such as the west weight router and the iact routers.
- Selects one requester per cycle using round-robin with a bounded burst lock, and drives the GLB address and request.
- Tracks each in-flight read through a fixed-latency tag pipeline and steers the returned data and a valid strobe back to the requester that issued it.
- Sits between the router array and the GLB.

Parameters:
- DATA_BITWIDTH, 16, GLB data word width.
- ADDR_BITWIDTH_GLB, 10, GLB address width.
- N_REQ, 4, number of requesters (2..8).
- READ_LATENCY, 1, cycles from glb_req_o high to glb_data_i valid (1..4).
- MAX_BURST, 8, maximum consecutive grants to one requester before re-arbitration (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_i  in  N_REQ  per-requester read request (level).
- addr_i  in  N_REQ*ADDR_BITWIDTH_GLB  flattened addresses; requester k uses slice [k*ADDR_BITWIDTH_GLB +: ADDR_BITWIDTH_GLB].
- gnt_o  out  N_REQ  one-hot grant; the address is consumed this cycle.
- glb_addr_o  out  ADDR_BITWIDTH_GLB  GLB read address.
- glb_req_o  out  1  GLB read strobe.
- glb_data_i  in  DATA_BITWIDTH  GLB read data.
- rdata_o  out  DATA_BITWIDTH  returned data, broadcast to all requesters.
- rvalid_o  out  N_REQ  one-hot return strobe; high when rdata_o belongs to requester k.
- busy_o  out  1  high while any read is in flight or a grant is active.

Behaviour:
- Reset (reset=0, asynchronous):
  - gnt_o, glb_req_o, rvalid_o and busy_o = 0; glb_addr_o = 0; rdata_o = 0.
  - rr_ptr = 0, burst_cnt = 0, FSM = IDLE.
  - The tag pipeline is cleared, so in-flight reads are discarded and no stale rvalid_o is produced after reset release.
- Grant is combinational from registered state and req_i:
  - gnt_o[k] is high in the same cycle as req_i[k].
  - glb_addr_o = addr_i slice of the granted requester; glb_req_o = |gnt_o.
  - When there is no grant, glb_addr_o holds its last value and glb_req_o = 0.
- FSM IDLE:
  - Grant the first requester with req_i high, searching from rr_ptr upward and wrapping modulo N_REQ.
  - Register owner = k, burst_cnt = 1, go to LOCK. If no requests, stay in IDLE.
- FSM LOCK:
  - If req_i[owner]=1 and burst_cnt < MAX_BURST: grant owner again and increment burst_cnt.
  - If req_i[owner]=0, or burst_cnt == MAX_BURST: set rr_ptr = (owner+1) mod N_REQ.
    - In the same cycle, pick a new owner by round-robin from the new rr_ptr. This may be the same owner only if no other requester has req_i high.
    - burst_cnt = 1 on a new grant; go to IDLE with no grant if nobody is requesting.
  - No grant bubble occurs on owner handover.
- MAX_BURST=1 gives pure per-cycle round-robin.
- Return path:
  - A shift register of depth READ_LATENCY holds {valid, tag} with tag = index of the granted requester.
  - At stage READ_LATENCY-1: rvalid_o[tag] = valid, and rdata_o = glb_data_i registered by one cycle aligned with rvalid_o.
  - Total latency from grant to rvalid_o is READ_LATENCY+1 cycles.
- The GLB is never back-pressured: one request per cycle, full throughput.
- busy_o = (FSM==LOCK) | any valid bit in the tag pipe.
- Requester address slices are not registered; requesters must hold addr_i stable while req_i is high.

Optional Feature:
- Macro GLB_ARB_FIXED_PRIO_EN.
  - Defined: rr_ptr is held at 0, so the lowest-index requester always wins at each re-arbitration point. The MAX_BURST limit still forces a re-arbitration check.
  - Undefined: round-robin as specified above.

Decomposition:
- Shared package glb_arb_pkg:
  - FSM state typedef (IDLE, LOCK).
  - Tag width constant TAG_W = clog2(N_REQ).
  - Function rr_pick(req, ptr), returning a one-hot grant and an index.
- One sub-module, glb_ret_pipe: the READ_LATENCY-deep {valid, tag} shift register plus the data retiming register. It outputs rvalid_o and rdata_o.

Test Plan:
- Single requester: req_i=4'b0010 held 3 cycles, addrs 0x010..0x012, READ_LATENCY=1.
  - Expect gnt_o=0010 for 3 cycles.
  - rvalid_o[1] high on cycles 2..4 with GLB model data for 0x010..0x012.
- Burst limit: MAX_BURST=4, req_i=4'b0011 held.
  - Expect grants 1,1,1,1 to req0, then 4 to req1, alternating, with zero idle cycles.
- Early release: req0 drops after 2 grants while req2 is pending.
  - Next cycle gnt_o=0100, and rr_ptr advances to 1.
- Latency tagging: READ_LATENCY=3, interleaved grants to req0 and req3.
  - rvalid_o order matches grant order, delayed 4 cycles; data per tag is correct.
- Reset mid-operation: assert reset=0 with 2 reads in flight.
  - All outputs go to 0 immediately; after release, no rvalid_o until a new grant.
- GLB_ARB_FIXED_PRIO_EN: req_i=4'b1111 constant, MAX_BURST=2.
  - req0 holds the grant continuously; req3 is never granted.
